load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes a core request, runs one word-aligned bus
// transaction with a bounded wait, and returns extended load data or an error.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [7:0]  wait_cnt_q;
    logic        mem_valid_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wmask_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic [1:0]  rsp_err_q;

    logic        illegal;
    logic        misaligned;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Request decode works on the live inputs; results are only used on the accept edge.
    always_comb begin
        illegal = 1'b1;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = req_we;
            default:                illegal = 1'b1;
        endcase

        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));

        st_mask = 4'b1111;
        st_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                st_mask = 4'b0001 << req_addr[1:0];
                st_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = req_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{req_wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = req_wdata;
            end
        endcase
    end

    // Lane selection and extension use the registered request, not the live inputs.
    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        ld_data = 32'h0;
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_data = mem_rdata;
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            wait_cnt_q  <= 8'h00;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wmask_q <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        off_q    <= req_addr[1:0];
                        if (illegal || misaligned) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= illegal ? 2'b10 : 2'b01;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state_q     <= BUS;
                            wait_cnt_q  <= 8'h00;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_wdata_q <= st_data;
                            mem_wmask_q <= req_we ? st_mask : 4'b0000;
                        end
                    end
                end
                BUS: begin
                    // A ready arriving on the last allowed cycle beats the timeout.
                    if (mem_ready) begin
                        state_q     <= RESP;
                        mem_valid_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 2'b00;
                        rsp_rdata_q <= we_q ? 32'h0 : ld_data;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                        if (wait_cnt_q == TIMEOUT_LAST) begin
                            state_q     <= RESP;
                            mem_valid_q <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 2'b11;
                            rsp_rdata_q <= 32'h0;
                        end
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    mem_valid_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;

endmodule
